// File: rtl/mem_resp_slave_pkg.sv
// Shared memory-responder constants: default storage window and the responder FSM encodings.
package mem_resp_slave_pkg;

    localparam logic [63:0] MEM_BASE  = 64'h8000_0000;
    localparam int          MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port byte-enabled array: combinational read, write on the rising edge.
// No handshake and no backpressure; the owner sequences every access.
module sram_1rw_be #(
    parameter int W     = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             wen,
    input  logic [W-1:0]     wdata,
    input  logic [W/8-1:0]   be,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < W/8; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_resp_slave.sv
// Memory responder: one request at a time, response valid LATENCY cycles after acceptance.
// Response is held until resp_ready; req_ready stays low from acceptance to the response handshake.
module mem_resp_slave
    import mem_resp_slave_pkg::*;
#(
    parameter int               XLEN      = 64,
    parameter int               DEPTH     = MEM_DEPTH,
    parameter logic [XLEN-1:0]  BASE_ADDR = XLEN'(MEM_BASE),
    parameter int               LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [XLEN-1:0] END_ADDR = BASE_ADDR + XLEN'(DEPTH * (XLEN/8));

    mem_state_t state, next_state;
    logic [3:0] cnt, cnt_next;
    logic       access;

    logic [XLEN-1:0]   cap_addr, cap_wdata;
    logic              cap_wen;
    logic [XLEN/8-1:0] cap_wstrb;

    logic [XLEN-1:0]   acc_addr, acc_aligned, acc_offset, acc_wdata;
    logic              acc_wen, acc_err;
    logic [XLEN/8-1:0] acc_wstrb;
    logic [AW-1:0]     acc_idx;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_wen;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        access     = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (req_valid) begin
                    cnt_next = 4'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        next_state = MEM_WAIT;
                    end else begin
                        next_state = MEM_RESP;
                        access     = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    next_state = MEM_RESP;
                    access     = 1'b1;
                end
            end
            MEM_RESP: begin
                if (resp_ready) next_state = MEM_IDLE;
            end
            default: next_state = MEM_IDLE;
        endcase
    end

    // With LATENCY=1 the access edge is the acceptance edge, so the live request is used.
    always_comb begin
        acc_addr    = (state == MEM_IDLE) ? req_addr  : cap_addr;
        acc_wen     = (state == MEM_IDLE) ? req_wen   : cap_wen;
        acc_wdata   = (state == MEM_IDLE) ? req_wdata : cap_wdata;
        acc_wstrb   = (state == MEM_IDLE) ? req_wstrb : cap_wstrb;
        acc_aligned = acc_addr & ~XLEN'(7);
        acc_offset  = acc_aligned - BASE_ADDR;
        acc_idx     = AW'(acc_offset >> 3);
        acc_err     = (acc_aligned < BASE_ADDR) || (acc_aligned >= END_ADDR);
        mem_wen     = access && acc_wen && !acc_err && !rst;
    end

    sram_1rw_be #(
        .W     (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .addr  (acc_idx),
        .wen   (mem_wen),
        .wdata (acc_wdata),
        .be    (acc_wstrb),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == MEM_IDLE && req_valid) begin
            cap_addr  <= req_addr;
            cap_wen   <= req_wen;
            cap_wdata <= req_wdata;
            cap_wstrb <= req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MEM_IDLE;
            cnt        <= 4'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (access) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || acc_wen) ? '0 : mem_rdata;
            end else if (state == MEM_RESP && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    assign req_ready  = (state == MEM_IDLE);
    assign resp_valid = (state == MEM_RESP);

endmodule

// File: tb/tb_mem_resp_slave.sv
// Directed bench: three responders (LATENCY 2, 4, 1) share request inputs, each has its own req_valid.
module tb_mem_resp_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid, req_ready, resp_valid, resp_err;
    logic [63:0] req_addr, req_wdata;
    logic        req_wen;
    logic [7:0]  req_wstrb;
    logic        resp_ready;
    logic [63:0] resp_rdata [3];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    mem_resp_slave #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]));

    mem_resp_slave #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]));

    mem_resp_slave #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]));

    // lat = number of edges from acceptance until resp_valid is sampled high; -1 if never accepted.
    task automatic run_txn(input int d, input logic w, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] strb,
                           output logic [63:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        resp_ready   = 1'b1;
        req_addr     = addr;
        req_wen      = w;
        req_wdata    = wdata;
        req_wstrb    = strb;
        req_valid[d] = 1'b1;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr     = addr ^ 64'h8;
        req_wen      = ~w;
        req_wdata    = ~wdata;
        req_wstrb    = ~strb;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        if (guard >= 50) lat = -1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 3'b000;
        resp_ready = 1'b1;
        req_addr = 64'h0; req_wen = 1'b0; req_wdata = 64'h0; req_wstrb = 8'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            vec++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 64'h0 || resp_err[d] !== 1'b0) begin
                miss++;
                $display("FAIL reset[%0d]: ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat;
        run_txn(0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, rd, er, lat);
        vec++;
        if (lat !== 2 || rd !== 64'h0 || er !== 1'b0) begin
            miss++;
            $display("FAIL write_full: lat=%0d rdata=%h err=%b, need 2 0 0", lat, rd, er);
        end
        run_txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (lat !== 2 || rd !== 64'h1122334455667788 || er !== 1'b0) begin
            miss++;
            $display("FAIL read_full: lat=%0d rdata=%h err=%b, need 2 1122334455667788 0", lat, rd, er);
        end
    endtask

    task automatic test_partial();
        logic [63:0] rd; logic er; int lat;
        run_txn(0, 1'b1, 64'h8000_0010, 64'hAAAAAAAABBBBBBBB, 8'h0F, rd, er, lat);
        run_txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'h11223344BBBBBBBB || er !== 1'b0) begin
            miss++;
            $display("FAIL partial: rdata=%h err=%b, need 11223344bbbbbbbb 0", rd, er);
        end
        run_txn(0, 1'b1, 64'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, rd, er, lat);
        vec++;
        if (lat !== 2 || rd !== 64'h0 || er !== 1'b0) begin
            miss++;
            $display("FAIL zero_strb_resp: lat=%0d rdata=%h err=%b, need 2 0 0", lat, rd, er);
        end
        run_txn(0, 1'b0, 64'h8000_0015, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'h11223344BBBBBBBB || er !== 1'b0) begin
            miss++;
            $display("FAIL zero_strb_unaligned_read: rdata=%h err=%b, need 11223344bbbbbbbb 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er; int lat;
        run_txn(0, 1'b1, 64'h8000_0000, 64'h5555666677778888, 8'hFF, rd, er, lat);
        run_txn(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'h0 || er !== 1'b1 || lat !== 2) begin
            miss++;
            $display("FAIL err_below: lat=%0d rdata=%h err=%b, need 2 0 1", lat, rd, er);
        end
        run_txn(0, 1'b0, 64'h8000_2000, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'h0 || er !== 1'b1) begin
            miss++;
            $display("FAIL err_above: rdata=%h err=%b, need 0 1", rd, er);
        end
        run_txn(0, 1'b1, 64'h8000_2000, 64'hDEADBEEFDEADBEEF, 8'hFF, rd, er, lat);
        vec++;
        if (rd !== 64'h0 || er !== 1'b1) begin
            miss++;
            $display("FAIL err_write_resp: rdata=%h err=%b, need 0 1", rd, er);
        end
        run_txn(0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'h5555666677778888 || er !== 1'b0) begin
            miss++;
            $display("FAIL err_write_no_alias: rdata=%h err=%b, need 5555666677778888 0", rd, er);
        end
        run_txn(0, 1'b1, 64'h8000_1FF8, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er, lat);
        run_txn(0, 1'b0, 64'h8000_1FF8, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'h0F0E0D0C0B0A0908 || er !== 1'b0) begin
            miss++;
            $display("FAIL last_word: rdata=%h err=%b, need 0f0e0d0c0b0a0908 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        resp_ready   = 1'b0;
        req_addr     = 64'h8000_0010;
        req_wen      = 1'b0;
        req_wstrb    = 8'h00;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        guard = 0;
        while (!resp_valid[0] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 ||
                resp_rdata[0] !== 64'h11223344BBBBBBBB || resp_err[0] !== 1'b0) begin
                miss++;
                $display("FAIL stall[%0d]: valid=%b ready=%b rdata=%h err=%b, need 1 0 11223344bbbbbbbb 0",
                         i, resp_valid[0], req_ready[0], resp_rdata[0], resp_err[0]);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 64'h0) begin
            miss++;
            $display("FAIL after_handshake: ready=%b valid=%b rdata=%h, need 1 0 0",
                     req_ready[0], resp_valid[0], resp_rdata[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat;
        logic seen;
        run_txn(1, 1'b1, 64'h8000_0020, 64'hCAFEF00D12345678, 8'hFF, rd, er, lat);
        vec++;
        if (lat !== 4 || rd !== 64'h0 || er !== 1'b0) begin
            miss++;
            $display("FAIL lat4_write: lat=%0d rdata=%h err=%b, need 4 0 0", lat, rd, er);
        end
        @(negedge clk);
        req_addr     = 64'h8000_0020;
        req_wen      = 1'b1;
        req_wdata    = 64'h0BADC0DE0BADC0DE;
        req_wstrb    = 8'hFF;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = resp_valid[1];
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if (req_ready[1] !== 1'b1 || resp_rdata[1] !== 64'h0 || resp_err[1] !== 1'b0) begin
            miss++;
            $display("FAIL mid_reset_state: ready=%b rdata=%h err=%b, need 1 0 0",
                     req_ready[1], resp_rdata[1], resp_err[1]);
        end
        for (int i = 0; i < 6; i++) begin
            seen = seen | resp_valid[1];
            @(negedge clk);
        end
        vec++;
        if (seen !== 1'b0) begin
            miss++;
            $display("FAIL mid_reset_valid: resp_valid rose=%b, need 0", seen);
        end
        run_txn(1, 1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, er, lat);
        vec++;
        if (rd !== 64'hCAFEF00D12345678 || er !== 1'b0 || lat !== 4) begin
            miss++;
            $display("FAIL mid_reset_contents: lat=%0d rdata=%h err=%b, need 4 cafef00d12345678 0",
                     lat, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int lat;
        logic exp_v;
        run_txn(2, 1'b1, 64'h8000_0030, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
        vec++;
        if (lat !== 1 || rd !== 64'h0 || er !== 1'b0) begin
            miss++;
            $display("FAIL lat1_write: lat=%0d rdata=%h err=%b, need 1 0 0", lat, rd, er);
        end
        @(negedge clk);
        resp_ready   = 1'b1;
        req_addr     = 64'h8000_0030;
        req_wen      = 1'b0;
        req_wstrb    = 8'h00;
        req_valid[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_v = (i % 2 == 0);
            vec++;
            if (resp_valid[2] !== exp_v || req_ready[2] !== !exp_v ||
                resp_rdata[2] !== (exp_v ? 64'h0123456789ABCDEF : 64'h0)) begin
                miss++;
                $display("FAIL b2b[%0d]: valid=%b ready=%b rdata=%h, need valid=%b ready=%b",
                         i, resp_valid[2], req_ready[2], resp_rdata[2], exp_v, !exp_v);
            end
        end
        req_valid[2] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/mem_resp_slave.md
Name: mem_resp_slave

Overview:
- Memory-side responder for the core's load/store and instruction-fetch request port.
- Accepts one request at a time over a valid/ready request channel and performs a word-wide read or a byte-strobed write into internal storage.
- Returns data and error status over a valid/ready response channel after a programmable latency.
- Sits below the LS and IF stages in place of the simulated DPI memory, so the pipeline can be exercised against multi-cycle memory.

Parameters:
- XLEN, 64, data and address width.
- DEPTH, 1024, number of XLEN-bit words in storage; must be a power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to resp_valid rising; must be 1 to 15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  XLEN  byte address; bits [2:0] ignored.
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  XLEN  write data.
- req_wstrb  in  XLEN/8  byte enables for writes.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  XLEN  read data; 0 for writes and errors.
- resp_err  out  1  access fell outside the storage range.

Behaviour:
- Reset (rst high at an edge):
  - state goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, resp_valid=0.
  - On req_valid: capture addr, wen, wdata and wstrb; load counter=LATENCY-1.
  - Next state is WAIT if LATENCY>1, otherwise RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When the counter reaches 1, the next state is RESP.
- Transition into RESP (the access edge):
  - Error check: err = (addr < BASE_ADDR) or (addr >= BASE_ADDR + DEPTH*XLEN/8).
  - No error, write: each byte i with wstrb[i]=1 is written into mem[idx], where idx = (addr - BASE_ADDR) >> 3 truncated to log2(DEPTH) bits. resp_rdata=0.
  - No error, read: resp_rdata = mem[idx], using pre-write contents.
  - Error: no storage update; resp_rdata=0; resp_err=1.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - resp_valid && resp_ready: next state IDLE; resp_rdata and resp_err are cleared to 0.
  - req_ready stays 0 throughout RESP. No new request is accepted in the cycle the response handshakes.
- Latency:
  - Request accepted at edge N gives resp_valid=1 from edge N+LATENCY.
  - Minimum issue interval is LATENCY+1 cycles per transaction.
- Request-side inputs are sampled only at the acceptance edge; changes while busy are ignored.
- A write with wstrb=0 is legal: no bytes change, and a normal response is returned.
- rst asserted in WAIT or RESP: the transaction is dropped. resp_valid falls at that edge. A write whose access edge has not occurred is not performed.
- A response is never dropped: resp_ready low holds RESP indefinitely.

Decomposition:
- Shared defines (existing defines file) gain:
  - `MEM_BASE, `MEM_DEPTH.
  - State encodings MEM_IDLE=2'd0, MEM_WAIT=2'd1, MEM_RESP=2'd2.
- One sub-module, sram_1rw_be:
  - single-port, synchronous-write, combinational-read array;
  - inputs: addr, wen, wdata, byte enable;
  - output: rdata.
- mem_resp_slave holds the FSM, counter, range check and response registers.

Test Plan:
1. LATENCY=2. Write addr 0x8000_0010, wdata 0x1122334455667788, wstrb 0xFF, resp_ready=1. Then read the same address. Required:
   - resp_valid exactly 2 cycles after each acceptance;
   - write response has rdata=0, err=0;
   - read returns 0x1122334455667788.
2. Partial write: wstrb 0x0F, wdata 0xAAAAAAAABBBBBBBB to the same word, then read. Required: 0x11223344BBBBBBBB.
3. Error cases:
   - Read 0x7FFF_FFF8 and 0x8000_2000 (DEPTH=1024): err=1, rdata=0.
   - Write to 0x8000_2000 followed by read of 0x8000_0000: word 0 is unchanged.
4. Backpressure: read with resp_ready=0 for 5 cycles after resp_valid. Required:
   - resp_valid and rdata stable throughout;
   - req_ready=0 throughout;
   - req_ready=1 the cycle after the handshake.
5. Reset mid-operation: accept a write to 0x8000_0020 (LATENCY=4) and assert rst at cycle 2. Required:
   - resp_valid never rises;
   - a later read of 0x8000_0020 returns the prior contents.
6. LATENCY=1 with back-to-back requests held valid. Required:
   - one acceptance every 2 cycles;
   - resp_valid on the edge following each acceptance.
